// File: rtl/bounce_emulator.sv
// Seeded contact-bounce source: a level change on data_in becomes an odd train of LFSR-timed glitches ending at the new level.
// First data_out edge and busy one cycle after data_in is sampled; no backpressure, data_in is ignored until the settle completes.
module bounce_emulator #(
  parameter int         NUM_COUNTER_BITS = 3,
  parameter int         NUM_BOUNCES      = 2,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic data_out,
  output logic busy,
  output logic settled
);

  localparam int             N            = NUM_COUNTER_BITS;
  localparam logic [N-1:0]   HOLD_MAX     = '1;
  localparam logic [N-1:0]   HOLD_ONE     = N'(1);
  localparam logic [4:0]     TOGGLES_INIT = 5'(2 * NUM_BOUNCES);
  localparam bit             NO_BOUNCE    = (NUM_BOUNCES == 0);

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  state_t       state, state_nxt;
  logic [7:0]   lfsr;
  logic         lfsr_fb;
  logic [N-1:0] w;
  logic [N-1:0] hold, hold_nxt;
  logic [4:0]   toggles_left, toggles_nxt;
  logic         level, level_nxt;
  logic         target, target_nxt;
  logic         data_out_nxt, busy_nxt, settled_nxt;
  logic         start;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // A zero draw would stall the hold counter, so it is promoted to one cycle
  assign w     = (lfsr[N-1:0] == '0) ? HOLD_ONE : lfsr[N-1:0];
  assign start = (data_in != level);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = NO_BOUNCE ? SETTLE : BOUNCE;
        end
      end
      BOUNCE: begin
        if (hold == HOLD_ONE && toggles_left == 5'd1) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (hold == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_out_nxt = data_out;
    busy_nxt     = busy;
    settled_nxt  = 1'b0;
    hold_nxt     = hold;
    toggles_nxt  = toggles_left;
    level_nxt    = level;
    target_nxt   = target;
    unique case (state)
      IDLE: begin
        data_out_nxt = level;
        busy_nxt     = 1'b0;
        if (start) begin
          target_nxt   = data_in;
          data_out_nxt = data_in;
          busy_nxt     = 1'b1;
          toggles_nxt  = TOGGLES_INIT;
          hold_nxt     = NO_BOUNCE ? HOLD_MAX : w;
        end
      end
      BOUNCE: begin
        if (hold == HOLD_ONE) begin
          // The last toggle lands on target, then the full settle window follows
          data_out_nxt = ~data_out;
          toggles_nxt  = toggles_left - 5'd1;
          hold_nxt     = (toggles_left == 5'd1) ? HOLD_MAX : w;
        end else begin
          hold_nxt = hold - HOLD_ONE;
        end
      end
      SETTLE: begin
        data_out_nxt = target;
        if (hold == '0) begin
          level_nxt   = target;
          busy_nxt    = 1'b0;
          settled_nxt = 1'b1;
        end else begin
          hold_nxt = hold - HOLD_ONE;
        end
      end
      default: begin
        data_out_nxt = level;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr         <= LFSR_SEED;
      hold         <= '0;
      toggles_left <= '0;
      level        <= 1'b0;
      target       <= 1'b0;
      data_out     <= 1'b0;
      busy         <= 1'b0;
      settled      <= 1'b0;
    end else begin
      lfsr         <= {lfsr[6:0], lfsr_fb};
      hold         <= hold_nxt;
      toggles_left <= toggles_nxt;
      level        <= level_nxt;
      target       <= target_nxt;
      data_out     <= data_out_nxt;
      busy         <= busy_nxt;
      settled      <= settled_nxt;
    end
  end

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: seed A5 waveform with two bouncing instances worth of stimulus and a no-bounce instance.
// Edge numbers count rising edges after reset release; toggle edges below were worked out by hand from the LFSR sequence.
module tb_bounce_emulator;

  logic clk = 1'b0;
  logic reset;
  logic data_in, data_in0;
  logic data_out, busy, settled;
  logic data_out0, busy0, settled0;

  int checks = 0;
  int errors = 0;

  // Debouncer model state (accepts a level after 8 consecutive equal samples)
  logic db_level, last_dout;
  int   run_len, db_changes;

  // Rising sequence: widths 7,7,6,2 (draws CF,BF,A6,9A); falling sequence: widths 1,1,3,5 (draws 60,C1,83,1D)
  localparam int EDGES [10] = '{21, 28, 35, 41, 43, 52, 53, 54, 57, 62};

  bounce_emulator #(.NUM_COUNTER_BITS(3), .NUM_BOUNCES(2), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_out(data_out), .busy(busy), .settled(settled)
  );

  bounce_emulator #(.NUM_COUNTER_BITS(3), .NUM_BOUNCES(0), .LFSR_SEED(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in0),
    .data_out(data_out0), .busy(busy0), .settled(settled0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic exp_dout(input int k);
    int n = 0;
    for (int i = 0; i < 10; i++) begin
      if (EDGES[i] <= k) n++;
    end
    return (n % 2) == 1;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    data_in  = 1'b0;
    data_in0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset%0d dout", i), data_out, 1'b0);
      chk($sformatf("reset%0d busy", i), busy, 1'b0);
      chk($sformatf("reset%0d settled", i), settled, 1'b0);
      chk($sformatf("reset%0d dout0", i), data_out0, 1'b0);
      chk($sformatf("reset%0d busy0", i), busy0, 1'b0);
    end
    reset      = 1'b0;
    db_level   = 1'b0;
    last_dout  = 1'b0;
    run_len    = 0;
    db_changes = 0;
  endtask

  task automatic run(input int last);
    for (int k = 1; k <= last; k++) begin
      tick();
      chk($sformatf("dout@%0d", k), data_out, exp_dout(k));
      chk($sformatf("busy@%0d", k), busy, (k >= 21 && k <= 50) || (k >= 52 && k <= 69));
      chk($sformatf("settled@%0d", k), settled, (k == 51) || (k == 70));
      chk($sformatf("dout0@%0d", k), data_out0, k >= 21);
      chk($sformatf("busy0@%0d", k), busy0, k >= 21 && k <= 28);
      chk($sformatf("settled0@%0d", k), settled0, k == 29);
      if (data_out === last_dout) run_len++;
      else run_len = 1;
      last_dout = data_out;
      if (run_len >= 8 && data_out !== db_level) begin
        db_level = data_out;
        db_changes++;
        chk($sformatf("db_change_in_settle@%0d", k), busy, 1'b1);
      end
      if (k == 20) begin
        data_in  = 1'b1;
        data_in0 = 1'b1;
      end
      // Falls mid-BOUNCE of the rising sequence and must be ignored until IDLE
      if (k == 38) data_in = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    data_in  = 1'b0;
    data_in0 = 1'b0;

    do_reset();
    run(72);
    chk_int("db_changes_run1", db_changes, 2);

    // Reset while data_out is high in the middle of BOUNCE
    do_reset();
    run(37);
    do_reset();
    run(72);
    chk_int("db_changes_run2", db_changes, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
